ir_tcu_sequencer: RTL and testbench
===================================

# ir_tcu_sequencer

Instruction-register and timing-counter sequencer sitting directly upstream of the 6502 decode ROM. Each cycle it presents the current opcode (IR) and cycle count (TCU) to the decoder, and takes back the decoder's next-TCU value. At every opcode-fetch cycle it either latches the opcode from the data bus or injects the interrupt opcode for RESET/NMI/IRQ. It also honours RDY stalls on read cycles.

## Interface
- `INTERRUPT_OPCODE`, default 8'h00: opcode injected into IR when servicing RESET/NMI/IRQ (BRK).
- `i_clk` in 1: clock; all state updates on rising edge.
- `i_reset_n` in 1: reset, synchronous, active-low.
- `i_rdy` in 1: ready; low stalls the sequencer on read cycles only.
- `i_rw` in 1: current cycle direction from the decoder (1 = read, 0 = write).
- `i_data` in 8: data bus input; opcode source during fetch cycles.
- `i_tcu_next` in 3: next TCU value computed by the decoder; 0 ends the instruction.
- `i_nmi_n` in 1: NMI request, falling-edge sensitive.
- `i_irq_n` in 1: IRQ request, level sensitive, active-low.
- `i_irq_mask` in 1: processor I flag; 1 blocks IRQ.
- `o_ir` out 8: instruction register, to the decoder.
- `o_tcu` out 3: timing counter, to the decoder.
- `o_sync` out 1: high while `o_tcu == 0` (opcode fetch cycle); combinational from `o_tcu`.
- `o_interrupt` out 1: high for the whole instruction when IR holds an injected opcode.
- `o_interrupt_kind` out 2: 00 none/BRK, 01 IRQ, 10 NMI, 11 RESET. Stable for the whole instruction.

## Operation
- Reset (`i_reset_n` = 0 at a rising edge) loads: `o_ir` = `INTERRUPT_OPCODE`, `o_tcu` = 0, `o_interrupt` = 0, `o_interrupt_kind` = 00, `reset_pending` = 1, `nmi_pending` = 0, `nmi_prev` = 1. `o_sync` is therefore 1.
- Stall: when `i_rdy` = 0 and `i_rw` = 1, IR, TCU, `o_interrupt` and `o_interrupt_kind` hold.
  - NMI edge detection keeps running during a stall.
  - When `i_rw` = 0, `i_rdy` is ignored.
- Non-fetch cycle (`o_tcu` != 0, not stalled): `o_tcu` <= `i_tcu_next`. IR and the kind outputs hold.
- Fetch cycle (`o_tcu` == 0, not stalled): `o_tcu` <= `i_tcu_next`. IR is selected by priority:
  - `reset_pending`: IR <= `INTERRUPT_OPCODE`, kind <= 11, `o_interrupt` <= 1, `reset_pending` <= 0.
  - else `nmi_pending`: IR <= `INTERRUPT_OPCODE`, kind <= 10, `o_interrupt` <= 1, `nmi_pending` <= 0.
  - else `i_irq_n` = 0 and `i_irq_mask` = 0: IR <= `INTERRUPT_OPCODE`, kind <= 01, `o_interrupt` <= 1.
  - else: IR <= `i_data`, kind <= 00, `o_interrupt` <= 0.
- NMI edge detection:
  - `nmi_prev` <= `i_nmi_n` every non-reset cycle.
  - `nmi_prev` = 1 and `i_nmi_n` = 0 sets `nmi_pending`.
  - If a new edge coincides with the clear caused by an NMI injection, set wins.
  - Holding `i_nmi_n` low produces only one request.
- The injection decision at a fetch uses the registered `nmi_pending` only. An edge arriving during the fetch cycle itself is serviced at the following fetch.
- IRQ is not latched: a request deasserted before a fetch is lost.
- TCU arithmetic is 3-bit. Any `i_tcu_next` is accepted unchecked, and 7 -> 0 wraps naturally.

## Timing
- Latency: `i_data` at a fetch edge appears on `o_ir` the next cycle, with `o_tcu` = `i_tcu_next` (normally 1) in the same cycle.
- First cycle after reset release: a fetch. The next cycle shows IR = `INTERRUPT_OPCODE`, kind = 11, `o_interrupt` = 1.
- NMI latency: edge at cycle n -> `nmi_pending` at n+1 -> injected at the first non-stalled fetch edge at or after n+1.
- Reset asserted mid-instruction takes effect at the next rising edge. All pending NMI/IRQ state is discarded.

## Test plan
- Reset then normal fetch: hold reset 2 cycles, release, `i_data` = 8'hA9, `i_tcu_next` = 1.
  - Expect next cycle IR = 00, kind = 11, `o_interrupt` = 1.
  - Decoder returns 0 at TCU 6; at the following fetch IR = A9, kind = 00, `o_interrupt` = 0.
- Stall: mid-instruction at TCU 2, `i_rw` = 1, `i_rdy` = 0 for 3 cycles -> TCU stays 2 and IR unchanged. Repeat with `i_rw` = 0 -> TCU advances to `i_tcu_next`.
- NMI edge: drop `i_nmi_n` at TCU 3 and hold it low for 20 cycles.
  - Next fetch injects 00 with kind = 10.
  - The subsequent fetch loads `i_data` (no re-trigger while held low).
- IRQ masking: `i_irq_n` = 0 with `i_irq_mask` = 1 -> fetch loads 8'hEA. Clear the mask -> next fetch injects with kind = 01.
- Priority and coincidence:
  - NMI pending plus IRQ asserted at the same fetch -> kind = 10, then IRQ (still asserted, unmasked) at the next fetch -> kind = 01.
  - NMI edge in the fetch cycle itself -> serviced one fetch later.
- Reset mid-operation: assert reset at TCU 4 with `nmi_pending` = 1 -> next cycle TCU = 0, kind = 00, `o_interrupt` = 0. After release the first injection is kind = 11, not NMI.

Source files
------------

// File: rtl/ir_tcu_sequencer.sv
// Instruction-register / timing-counter sequencer feeding the 6502 decode ROM.
// Latches opcodes at fetch, injects the interrupt opcode for RESET/NMI/IRQ, honours RDY read stalls.
module ir_tcu_sequencer #(
    parameter logic [7:0] INTERRUPT_OPCODE = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rdy,
    input  logic       i_rw,
    input  logic [7:0] i_data,
    input  logic [2:0] i_tcu_next,
    input  logic       i_nmi_n,
    input  logic       i_irq_n,
    input  logic       i_irq_mask,
    output logic [7:0] o_ir,
    output logic [2:0] o_tcu,
    output logic       o_sync,
    output logic       o_interrupt,
    output logic [1:0] o_interrupt_kind
);

    localparam logic [1:0] KIND_NONE  = 2'b00;
    localparam logic [1:0] KIND_IRQ   = 2'b01;
    localparam logic [1:0] KIND_NMI   = 2'b10;
    localparam logic [1:0] KIND_RESET = 2'b11;

    logic [7:0] ir_q, ir_d;
    logic [2:0] tcu_q, tcu_d;
    logic       int_q, int_d;
    logic [1:0] kind_q, kind_d;
    logic       reset_pend_q, reset_pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_prev_q, nmi_prev_d;

    logic       stall;
    logic       fetch;
    logic       nmi_edge;
    logic       nmi_taken;

    assign stall    = ~i_rdy & i_rw;
    assign fetch    = (tcu_q == 3'd0) & ~stall;
    assign nmi_edge = nmi_prev_q & ~i_nmi_n;

    always_comb begin
        ir_d         = ir_q;
        tcu_d        = tcu_q;
        int_d        = int_q;
        kind_d       = kind_q;
        reset_pend_d = reset_pend_q;
        nmi_taken    = 1'b0;
        if (!stall) begin
            tcu_d = i_tcu_next;
        end
        if (fetch) begin
            if (reset_pend_q) begin
                ir_d         = INTERRUPT_OPCODE;
                kind_d       = KIND_RESET;
                int_d        = 1'b1;
                reset_pend_d = 1'b0;
            end else if (nmi_pend_q) begin
                ir_d      = INTERRUPT_OPCODE;
                kind_d    = KIND_NMI;
                int_d     = 1'b1;
                nmi_taken = 1'b1;
            end else if (!i_irq_n && !i_irq_mask) begin
                ir_d   = INTERRUPT_OPCODE;
                kind_d = KIND_IRQ;
                int_d  = 1'b1;
            end else begin
                ir_d   = i_data;
                kind_d = KIND_NONE;
                int_d  = 1'b0;
            end
        end
    end

    // A fresh edge outranks the clear from servicing the previous one, so no NMI is lost.
    always_comb begin
        nmi_prev_d = i_nmi_n;
        nmi_pend_d = nmi_pend_q;
        if (nmi_edge) begin
            nmi_pend_d = 1'b1;
        end else if (nmi_taken) begin
            nmi_pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ir_q         <= INTERRUPT_OPCODE;
            tcu_q        <= 3'd0;
            int_q        <= 1'b0;
            kind_q       <= KIND_NONE;
            reset_pend_q <= 1'b1;
            nmi_pend_q   <= 1'b0;
            nmi_prev_q   <= 1'b1;
        end else begin
            ir_q         <= ir_d;
            tcu_q        <= tcu_d;
            int_q        <= int_d;
            kind_q       <= kind_d;
            reset_pend_q <= reset_pend_d;
            nmi_pend_q   <= nmi_pend_d;
            nmi_prev_q   <= nmi_prev_d;
        end
    end

    assign o_ir             = ir_q;
    assign o_tcu            = tcu_q;
    assign o_sync           = (tcu_q == 3'd0);
    assign o_interrupt      = int_q;
    assign o_interrupt_kind = kind_q;

endmodule

// File: tb/tb_ir_tcu_sequencer.sv
// Directed bench for ir_tcu_sequencer: a cycle-level reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_ir_tcu_sequencer;

    localparam logic [7:0] INT_OP = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n, rdy, rw, nmi_n, irq_n, irq_mask;
    logic [7:0] data;
    logic [2:0] tcu_next;
    logic [7:0] o_ir;
    logic [2:0] o_tcu;
    logic       o_sync, o_interrupt;
    logic [1:0] o_kind;

    int checks = 0;
    int passed = 0;
    bit check_en = 1'b0;

    ir_tcu_sequencer #(.INTERRUPT_OPCODE(INT_OP)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_rdy(rdy), .i_rw(rw), .i_data(data),
        .i_tcu_next(tcu_next), .i_nmi_n(nmi_n), .i_irq_n(irq_n), .i_irq_mask(irq_mask),
        .o_ir(o_ir), .o_tcu(o_tcu), .o_sync(o_sync), .o_interrupt(o_interrupt),
        .o_interrupt_kind(o_kind)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: what the decoder should see, derived from the request rules.
    logic [7:0] m_ir;
    logic [2:0] m_tcu;
    logic       m_int;
    logic [1:0] m_kind;
    bit         m_reset_req, m_nmi_req, m_nmi_level;

    function automatic logic [1:0] pick_source(bit rst_req, bit nmi_req, bit irq_req);
        if (rst_req) return 2'b11;
        if (nmi_req) return 2'b10;
        if (irq_req) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        logic [1:0] src;
        bit         advancing, serviced_nmi, new_edge;
        if (!rst_n) begin
            m_ir <= INT_OP; m_tcu <= 3'd0; m_int <= 1'b0; m_kind <= 2'b00;
            m_reset_req <= 1'b1; m_nmi_req <= 1'b0; m_nmi_level <= 1'b1;
        end else begin
            advancing    = !(rw && !rdy);
            new_edge     = m_nmi_level && !nmi_n;
            serviced_nmi = 1'b0;
            m_nmi_level <= nmi_n;
            if (advancing) begin
                m_tcu <= tcu_next;
                if (m_tcu == 3'd0) begin
                    src = pick_source(m_reset_req, m_nmi_req, !irq_n && !irq_mask);
                    m_kind <= src;
                    m_int  <= (src != 2'b00);
                    m_ir   <= (src != 2'b00) ? INT_OP : data;
                    if (src == 2'b11) m_reset_req <= 1'b0;
                    if (src == 2'b10) serviced_nmi = 1'b1;
                end
            end
            m_nmi_req <= new_edge ? 1'b1 : (serviced_nmi ? 1'b0 : m_nmi_req);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ir", o_ir, m_ir);
            chk("tcu", o_tcu, m_tcu);
            chk("sync", o_sync, m_tcu == 3'd0);
            chk("interrupt", o_interrupt, m_int);
            chk("kind", o_kind, m_kind);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step_to(logic [2:0] nxt);
        tcu_next = nxt;
        tick();
    endtask

    task automatic expect_state(string tag, logic [7:0] ir, logic [2:0] tcu, logic intr, logic [1:0] kind);
        chk({tag, ".ir"}, o_ir, ir);
        chk({tag, ".tcu"}, o_tcu, tcu);
        chk({tag, ".int"}, o_interrupt, intr);
        chk({tag, ".kind"}, o_kind, kind);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; rw = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; irq_mask = 1'b1;
        data = 8'hA9; tcu_next = 3'd1;

        // Reset then normal fetch
        tick(); check_en = 1'b1;
        tick();
        expect_state("reset", INT_OP, 3'd0, 1'b0, 2'b00);
        chk("reset.sync", o_sync, 1);
        rst_n = 1'b1; data = 8'hA9; tcu_next = 3'd1;
        tick();
        expect_state("first_fetch", INT_OP, 3'd1, 1'b1, 2'b11);
        step_to(3'd2); step_to(3'd3); step_to(3'd4); step_to(3'd5); step_to(3'd6);
        chk("tcu6", o_tcu, 6);
        step_to(3'd0);
        chk("fetch.sync", o_sync, 1);
        step_to(3'd1);
        expect_state("normal_fetch", 8'hA9, 3'd1, 1'b0, 2'b00);

        // Read stall holds, write cycle ignores RDY
        step_to(3'd2);
        rdy = 1'b0; rw = 1'b1; tcu_next = 3'd3; data = 8'h55;
        tick(3);
        expect_state("stall_read", 8'hA9, 3'd2, 1'b0, 2'b00);
        rw = 1'b0;
        tick();
        chk("stall_write.tcu", o_tcu, 3);
        rdy = 1'b1; rw = 1'b1; data = 8'hA9;

        // NMI edge at TCU 3, held low across several instructions
        nmi_n = 1'b0;
        step_to(3'd0);
        step_to(3'd1);
        expect_state("nmi_inject", INT_OP, 3'd1, 1'b1, 2'b10);
        step_to(3'd0);
        data = 8'h4C;
        step_to(3'd1);
        expect_state("nmi_no_retrigger", 8'h4C, 3'd1, 1'b0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            step_to(3'd0);
            step_to(3'd1);
        end
        chk("nmi_held.kind", o_kind, 0);
        nmi_n = 1'b1;

        // IRQ masked then unmasked
        step_to(3'd0);
        irq_n = 1'b0; irq_mask = 1'b1; data = 8'hEA;
        step_to(3'd1);
        expect_state("irq_masked", 8'hEA, 3'd1, 1'b0, 2'b00);
        irq_mask = 1'b0;
        step_to(3'd0);
        step_to(3'd1);
        expect_state("irq_inject", INT_OP, 3'd1, 1'b1, 2'b01);
        irq_n = 1'b1;

        // NMI pending and IRQ at the same fetch
        nmi_n = 1'b0;
        step_to(3'd0);
        irq_n = 1'b0;
        step_to(3'd1);
        chk("prio.nmi_kind", o_kind, 2'b10);
        nmi_n = 1'b1;
        step_to(3'd0);
        step_to(3'd1);
        chk("prio.irq_kind", o_kind, 2'b01);
        irq_n = 1'b1;

        // NMI edge during the fetch cycle itself is serviced one fetch later
        step_to(3'd0);
        nmi_n = 1'b0; data = 8'hA9;
        step_to(3'd1);
        expect_state("nmi_late.first", 8'hA9, 3'd1, 1'b0, 2'b00);
        step_to(3'd0);
        step_to(3'd1);
        chk("nmi_late.kind", o_kind, 2'b10);
        nmi_n = 1'b1;

        // Stall on a fetch read; NMI edge during the stall still registers
        step_to(3'd0);
        rdy = 1'b0; data = 8'h11; tcu_next = 3'd1;
        tick();
        nmi_n = 1'b0;
        tick();
        expect_state("fetch_stall", INT_OP, 3'd0, 1'b1, 2'b10);
        rdy = 1'b1;
        tick();
        chk("stall_nmi.kind", o_kind, 2'b10);
        nmi_n = 1'b1;

        // Arbitrary next-TCU values, including 7
        step_to(3'd7);
        chk("tcu7", o_tcu, 7);
        chk("tcu7.sync", o_sync, 0);
        step_to(3'd0);

        // Reset mid-instruction with an NMI pending
        data = 8'hA9;
        step_to(3'd1); step_to(3'd2); step_to(3'd3);
        nmi_n = 1'b0;
        step_to(3'd4);
        rst_n = 1'b0; nmi_n = 1'b1; tcu_next = 3'd5;
        tick();
        expect_state("mid_reset", INT_OP, 3'd0, 1'b0, 2'b00);
        rst_n = 1'b1; tcu_next = 3'd1;
        tick();
        expect_state("post_reset", INT_OP, 3'd1, 1'b1, 2'b11);
        step_to(3'd0);
        step_to(3'd1);
        expect_state("nmi_discarded", 8'hA9, 3'd1, 1'b0, 2'b00);
        tick(2);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
